// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the program counter and issues one instruction fetch at a
// time. The returned word is buffered for decode, and PC advances by 4 when decode
// consumes it. A taken branch redirects PC to branch_pc + branch_imm from any state.
// A fetch that is still in flight during a redirect is marked stale (kill) and its
// response is dropped. A misaligned redirect target parks the block in FAULT until reset.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_BOOT  | first cycle after reset, no request yet
// S_REQ   | request for pc presented on imem, waiting for acceptance
// S_WAIT  | request accepted, waiting for the response (kill marks it stale)
// S_HOLD  | instruction buffered and offered to decode
// S_FAULT | misaligned redirect seen, everything idle until reset
module fetch_sequencer #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     branch_taken,
  input  logic [ADDRESS_WIDTH-1:0] branch_pc,
  input  logic [ADDRESS_WIDTH-1:0] branch_imm,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic                     imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]    imem_rsp_data,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [DATA_WIDTH-1:0]    instr_data,
  output logic [ADDRESS_WIDTH-1:0] instr_pc,
  output logic                     fault,
  output logic [ADDRESS_WIDTH-1:0] fault_pc
);

  typedef enum logic [2:0] {S_BOOT, S_REQ, S_WAIT, S_HOLD, S_FAULT} state_t;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic                     kill_q, kill_d;
  logic [DATA_WIDTH-1:0]    buf_data_q;
  logic [ADDRESS_WIDTH-1:0] buf_pc_q;
  logic                     buf_load;
  logic                     fault_q, fault_set;
  logic [ADDRESS_WIDTH-1:0] fault_pc_q;
  logic [ADDRESS_WIDTH-1:0] target;
  logic                     redirect_ok, redirect_bad;

  // Carry out of the add is dropped, so the target wraps modulo 2^ADDRESS_WIDTH.
  assign target       = branch_pc + branch_imm;
  assign redirect_ok  = branch_taken && (target[1:0] == 2'b00);
  assign redirect_bad = branch_taken && (target[1:0] != 2'b00);

  assign fault    = fault_q;
  assign fault_pc = fault_pc_q;

  // Next-state, PC update and output decode; a redirect always wins over the +4 advance
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    kill_d         = kill_q;
    buf_load       = 1'b0;
    fault_set      = 1'b0;
    imem_req_valid = 1'b0;
    imem_addr      = pc_q;
    instr_valid    = 1'b0;
    instr_data     = '0;
    instr_pc       = '0;

    case (state_q)
      S_BOOT: begin
        if (redirect_ok) pc_d = target;
        state_d = S_REQ;
      end
      S_REQ: begin
        imem_req_valid = 1'b1;
        if (redirect_ok) pc_d = target;
        // If the old address is accepted in a redirect cycle, its response is stale.
        if (imem_req_ready) begin
          state_d = S_WAIT;
          kill_d  = redirect_ok;
        end
      end
      S_WAIT: begin
        if (redirect_ok) pc_d = target;
        if (imem_rsp_valid) begin
          kill_d = 1'b0;
          if (kill_q || redirect_ok) begin
            state_d = S_REQ;
          end else begin
            buf_load = 1'b1;
            state_d  = S_HOLD;
          end
        end else if (redirect_ok) begin
          kill_d = 1'b1;
        end
      end
      S_HOLD: begin
        instr_valid = 1'b1;
        instr_data  = buf_data_q;
        instr_pc    = buf_pc_q;
        if (redirect_ok) begin
          pc_d    = target;
          state_d = S_REQ;
        end else if (instr_ready) begin
          pc_d    = pc_q + ADDRESS_WIDTH'(4);
          state_d = S_REQ;
        end
      end
      S_FAULT: begin
        imem_addr = '0;
      end
      default: begin
        state_d = S_FAULT;
      end
    endcase

    // A misaligned target overrides everything else, including an in-flight response.
    if (state_q != S_FAULT && redirect_bad) begin
      fault_set = 1'b1;
      buf_load  = 1'b0;
      pc_d      = pc_q;
      state_d   = S_FAULT;
    end
  end

  // State, PC, kill flag, instruction buffer and sticky fault registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      kill_q     <= 1'b0;
      buf_data_q <= '0;
      buf_pc_q   <= '0;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      if (buf_load) begin
        buf_data_q <= imem_rsp_data;
        buf_pc_q   <= pc_q;
      end
      if (fault_set) begin
        fault_q    <= 1'b1;
        fault_pc_q <= target;
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a memory model answers accepted requests after a
// programmable latency. The reference model tracks which PC decode should receive
// next, and a negedge monitor checks every consumed instruction against that queue.
module tb_fetch_sequencer;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          branch_taken = 1'b0;
  logic [AW-1:0] branch_pc = '0;
  logic [AW-1:0] branch_imm = '0;
  logic          imem_req_valid;
  logic          imem_req_ready = 1'b0;
  logic [AW-1:0] imem_addr;
  logic          imem_rsp_valid = 1'b0;
  logic [DW-1:0] imem_rsp_data = '0;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [DW-1:0] instr_data;
  logic [AW-1:0] instr_pc;
  logic          fault;
  logic [AW-1:0] fault_pc;

  always #5 clk = ~clk;

  fetch_sequencer #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC('0)) dut (
    .clk(clk), .rst(rst),
    .branch_taken(branch_taken), .branch_pc(branch_pc), .branch_imm(branch_imm),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
    .instr_pc(instr_pc), .fault(fault), .fault_pc(fault_pc)
  );

  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            delivered = 0;
  logic [AW-1:0] sb_q[$];
  logic [AW-1:0] exp_pc;
  logic          model_fault;
  logic [AW-1:0] acc_q[$];
  int            acc_cyc[$];
  logic          pend = 1'b0;
  logic [AW-1:0] paddr;
  int            plat;
  int            lat_min = 0;
  int            lat_max = 0;
  logic [AW-1:0] mon_e;

  function automatic logic [DW-1:0] mem_word(logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every instruction decode takes must be the next one the model expects
  always @(negedge clk) begin
    if (!rst && instr_valid && instr_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got instr_pc 0x%0h expected none", instr_pc);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_instr_pc", instr_pc, mon_e);
        chk("sb_instr_data", instr_data, mem_word(mon_e));
      end
      delivered++;
    end
  end

  // One clock: sample handshakes at negedge, then update model and memory after posedge
  task automatic tick();
    logic fire, cons, br;
    logic [AW-1:0] a, tgt;
    @(negedge clk);
    fire = imem_req_valid && imem_req_ready;
    a    = imem_addr;
    cons = instr_valid && instr_ready;
    br   = branch_taken;
    tgt  = branch_pc + branch_imm;
    @(posedge clk);
    #1;
    cyc++;
    if (!model_fault) begin
      if (br && tgt[1:0] != 2'b00) begin
        model_fault = 1'b1;
        sb_q.delete();
      end else if (br) begin
        exp_pc = tgt;
        sb_q.delete();
        sb_q.push_back(exp_pc);
      end else if (cons) begin
        exp_pc = exp_pc + 32'd4;
        sb_q.push_back(exp_pc);
      end
    end
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (fire) begin
      acc_q.push_back(a);
      acc_cyc.push_back(cyc);
      pend  = 1'b1;
      paddr = a;
      plat  = int'($urandom_range(lat_max, lat_min));
    end
    if (pend) begin
      if (plat == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(paddr);
        pend = 1'b0;
      end else begin
        plat--;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    branch_taken = 1'b0;
    imem_req_ready = 1'b0;
    instr_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    pend = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_pc = '0;
    model_fault = 1'b0;
    sb_q.delete();
    sb_q.push_back('0);
    acc_q.delete();
    acc_cyc.delete();
    cyc = 0;
  endtask

  task automatic wait_valid(string name, int budget);
    int n;
    n = 0;
    while (!instr_valid && n < budget) begin
      tick();
      n++;
    end
    if (!instr_valid) begin
      checks++;
      failures++;
      $display("FAIL %s: got no instr_valid expected instr_valid within %0d cycles", name, budget);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, d0;

    // Reset state, then straight-line fetch of 0x0, 0x4, 0x8 at one per 3 cycles
    do_reset();
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instr_data", instr_data, 0);
    chk("rst_instr_pc", instr_pc, 0);
    chk("rst_fault", fault, 0);
    chk("rst_fault_pc", fault_pc, 0);
    lat_min = 0; lat_max = 0;
    imem_req_ready = 1'b1;
    instr_ready = 1'b1;
    tick();
    chk("t1_first_req", imem_req_valid, 1);
    repeat (8) tick();
    chk("t1_acc_count", acc_q.size(), 3);
    if (acc_q.size() >= 3) begin
      chk("t1_addr0", acc_q[0], 32'h0);
      chk("t1_addr1", acc_q[1], 32'h4);
      chk("t1_addr2", acc_q[2], 32'h8);
      chk("t1_spacing01", acc_cyc[1] - acc_cyc[0], 3);
      chk("t1_spacing12", acc_cyc[2] - acc_cyc[1], 3);
    end

    // Memory stalls for 5 cycles: request and address held, single acceptance
    do_reset();
    imem_req_ready = 1'b0;
    instr_ready = 1'b0;
    tick();
    repeat (5) begin
      tick();
      chk("t2_req_held", imem_req_valid, 1);
      chk("t2_addr_held", imem_addr, 32'h0);
    end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    repeat (3) tick();
    chk("t2_acc_count", acc_q.size(), 1);
    chk("t2_hold", instr_valid, 1);

    // Decode stalls 4 cycles in HOLD at pc 0x8
    do_reset();
    imem_req_ready = 1'b1;
    wait_valid("t3_v0", 20);
    instr_ready = 1'b1; tick(); instr_ready = 1'b0;
    wait_valid("t3_v4", 20);
    instr_ready = 1'b1; tick(); instr_ready = 1'b0;
    wait_valid("t3_v8", 20);
    chk("t3_pc", instr_pc, 32'h8);
    n0 = acc_q.size();
    repeat (4) begin
      tick();
      chk("t3_valid", instr_valid, 1);
      chk("t3_data", instr_data, mem_word(32'h8));
      chk("t3_no_req", imem_req_valid, 0);
    end
    chk("t3_acc_count", acc_q.size(), n0);

    // Redirect while waiting; the stale response arrives 2 cycles later
    lat_min = 2; lat_max = 2;
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    tick();
    imem_req_ready = 1'b0;
    branch_taken = 1'b1; branch_pc = 32'h8; branch_imm = 32'hFFFF_FFF0;
    tick();
    branch_taken = 1'b0;
    repeat (2) begin
      tick();
      chk("t4_no_instr", instr_valid, 0);
    end
    chk("t4_req_valid", imem_req_valid, 1);
    chk("t4_addr", imem_addr, 32'hFFFF_FFF8);
    tick();
    chk("t4_no_instr_late", instr_valid, 0);

    // Redirect together with consumption in HOLD
    lat_min = 0; lat_max = 0;
    imem_req_ready = 1'b1;
    wait_valid("t5_v", 20);
    chk("t5_pc", instr_pc, 32'hFFFF_FFF8);
    d0 = delivered;
    branch_taken = 1'b1; branch_pc = 32'h4; branch_imm = 32'h20; instr_ready = 1'b1;
    tick();
    branch_taken = 1'b0; instr_ready = 1'b0;
    chk("t5_consumed", delivered - d0, 1);
    chk("t5_req_valid", imem_req_valid, 1);
    chk("t5_addr", imem_addr, 32'h24);

    // Misaligned redirect: sticky fault, no more requests, reset clears it
    imem_req_ready = 1'b0;
    branch_taken = 1'b1; branch_pc = 32'h100; branch_imm = 32'h2;
    tick();
    branch_taken = 1'b0;
    chk("t6_fault", fault, 1);
    chk("t6_fault_pc", fault_pc, 32'h102);
    chk("t6_req_valid", imem_req_valid, 0);
    chk("t6_instr_valid", instr_valid, 0);
    n0 = acc_q.size();
    imem_req_ready = 1'b1;
    branch_taken = 1'b1; branch_pc = 32'h0; branch_imm = 32'h40;
    tick();
    branch_taken = 1'b0;
    repeat (3) tick();
    chk("t6_no_req", acc_q.size(), n0);
    chk("t6_fault_pc_kept", fault_pc, 32'h102);
    chk("t6_fault_kept", fault, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_rst_fault", fault, 0);
    chk("t6_rst_fault_pc", fault_pc, 0);
    chk("t6_rst_addr", imem_addr, 0);
    do_reset();
    imem_req_ready = 1'b1;
    tick();
    chk("t6_restart_req", imem_req_valid, 1);
    chk("t6_restart_addr", imem_addr, 32'h0);

    // Stray response right after reset release must be ignored
    do_reset();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    tick();
    imem_req_ready = 1'b1;
    wait_valid("t7_v", 20);
    chk("t7_pc", instr_pc, 32'h0);
    chk("t7_data", instr_data, mem_word(32'h0));

    // Randomized traffic against the scoreboard
    do_reset();
    lat_min = 0; lat_max = 3;
    d0 = delivered;
    for (int i = 0; i < 3000; i++) begin
      imem_req_ready = ($urandom_range(3, 0) != 0);
      instr_ready    = $urandom_range(1, 0) != 0;
      branch_taken   = ($urandom_range(9, 0) == 0);
      branch_pc      = $urandom & 32'hFFFF_FFFC;
      branch_imm     = $urandom & 32'hFFFF_FFFC;
      tick();
    end
    branch_taken = 1'b0;
    chk("rand_progress", (delivered - d0) > 100, 1);
    chk("rand_no_fault", fault, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller that owns the program counter and sequences it against a handshaked instruction memory. Issues one fetch at a time, buffers the returned word for decode, advances PC by 4 on consumption, and applies taken-branch redirects (branch PC + immediate) from the control unit at any point, discarding stale in-flight fetches. Sits between the control unit and sign-extend block on one side, and instruction memory and decode on the other.

## Interface
- ADDRESS_WIDTH, 32, width of PC and memory address
- DATA_WIDTH, 32, instruction word width
- RESET_PC, 0, PC value loaded by reset
- clk  input  1  single clock, all state updates on posedge
- rst  input  1  asynchronous, active-high reset
- branch_taken  input  1  control unit: redirect this cycle (PCsrc)
- branch_pc  input  ADDRESS_WIDTH  PC of the branch instruction
- branch_imm  input  ADDRESS_WIDTH  sign-extended offset (ImmOp)
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request
- imem_addr  output  ADDRESS_WIDTH  fetch address (current PC)
- imem_rsp_valid  input  1  response data valid
- imem_rsp_data  input  DATA_WIDTH  returned instruction
- instr_valid  output  1  buffered instruction valid to decode
- instr_ready  input  1  decode consumes instruction
- instr_data  output  DATA_WIDTH  buffered instruction
- instr_pc  output  ADDRESS_WIDTH  address of buffered instruction
- fault  output  1  sticky misaligned-redirect flag
- fault_pc  output  ADDRESS_WIDTH  offending target address

## Operation
- Registers: pc, state, kill flag, instr buffer (data + pc), fault, fault_pc.
- Target = branch_pc + branch_imm, modulo 2^ADDRESS_WIDTH (carry dropped).
- States: BOOT, REQ, WAIT, HOLD, FAULT.
- BOOT: all outputs 0; next cycle -> REQ.
- REQ: imem_req_valid=1, imem_addr=pc. imem_req_ready=1 -> WAIT (kill=0).
- WAIT: imem_req_valid=0. imem_rsp_valid=1: kill=0 -> capture data, instr_pc<=pc, -> HOLD; kill=1 -> discard, clear kill, -> REQ.
- HOLD: instr_valid=1. instr_ready=1 -> pc<=pc+4, -> REQ.
- Redirect (branch_taken=1, target[1:0]==0), highest priority over +4:
  - REQ without ready: pc<=target, stay REQ. REQ with ready: handshake for old address completes, pc<=target, -> WAIT with kill=1.
  - WAIT: pc<=target, kill=1; if imem_rsp_valid same cycle, response discarded, -> REQ.
  - HOLD: buffer dropped (instr_valid low next cycle) regardless of instr_ready; pc<=target, -> REQ.
  - BOOT: pc<=target, -> REQ.
- Misaligned redirect (target[1:0]!=0) in any non-FAULT state: fault<=1, fault_pc<=target, -> FAULT; in-flight response ignored.
- FAULT: all request/instr outputs 0; only reset exits.
- imem_rsp_valid outside WAIT is ignored. branch_taken in FAULT ignored.

## Timing
- Reset values: pc=RESET_PC, state=BOOT, kill=0, imem_req_valid=0, imem_addr=RESET_PC, instr_valid=0, instr_data=0, instr_pc=0, fault=0, fault_pc=0.
- Reset asserted mid-operation: immediate return to reset values; pending memory response after release is ignored (arrives outside WAIT or before new request accepted).
- First request: imem_req_valid=1 in the second cycle after rst deasserts.
- One outstanding request max. Memory response no earlier than cycle after acceptance.
- Best-case throughput: 1 instruction per 3 cycles (REQ accepted, WAIT with response, HOLD consumed).
- imem_addr and imem_req_valid stable while REQ unaccepted, except on redirect (address changes to target).
- instr_valid/instr_data/instr_pc stable in HOLD until instr_ready or redirect.
- Redirect to new request on imem: 1 cycle (from HOLD/REQ) or after stale response (from WAIT).

## Test plan
- Reset release, memory always ready, 1-cycle response, decode always ready: imem_addr sequence 0x0, 0x4, 0x8; instr_pc matches; one instruction per 3 cycles.
- imem_req_ready low 5 cycles then high: imem_req_valid held, imem_addr=0x0 throughout, single WAIT entry.
- In HOLD at pc 0x8, instr_ready=0 for 4 cycles: instr_valid stays 1, instr_data unchanged, no new request.
- branch_taken in WAIT with branch_pc=0x8, branch_imm=0xFFFFFFF0 (target 0xFFFFFFF8), response 2 cycles later: response discarded, instr_valid never asserted for it, next imem_addr=0xFFFFFFF8.
- branch_taken with instr_ready same cycle in HOLD, branch_pc=0x4, branch_imm=0x20: instruction consumed, next imem_addr=0x24 (not 0x8).
- Redirect target 0x102: fault=1, fault_pc=0x102, no further requests; rst pulse mid-FAULT restores fault=0, pc=RESET_PC.
